reduce_pipe: RTL
================

# reduce_pipe

Parametrised, pipelined N-input reduction unit: the generalised successor of the fixed 8-input AND cell. It reduces a WIDTH-bit operand with a per-beat selectable operator (AND/OR/XOR/NAND) through a tree of FANIN-input levels, registering each level. It sits in the unit-design suite as a timing-closable reduction primitive with valid/ready flow control, so post-route netlists can be checked against RTL under back-pressure.

## Interface
- WIDTH, 8: operand width, legal range 1..256.
- FANIN, 4: inputs per tree node (LUT-sized), legal range 2..6.
- LEVELS (localparam): max(1, ceil(log_FANIN(WIDTH))). WIDTH=8, FANIN=4 gives 2. WIDTH=7, FANIN=3 gives 2.
- clk, input, 1: the single clock. All logic is rising-edge.
- reset, input, 1: synchronous, active-high.
- a, input, WIDTH: operand.
- op, input, 2: operator. 00 AND, 01 OR, 10 XOR (parity), 11 NAND.
- in_valid, input, 1: a/op present a beat.
- in_ready, output, 1: the beat is accepted when in_valid && in_ready.
- b, output, 1: reduction result.
- out_valid, output, 1: b holds a result.
- out_ready, input, 1: the consumer takes the result when out_valid && out_ready.
- out_count, output, 16: number of results delivered. Saturates at 0xFFFF.

## Operation
- Pipeline structure:
  - LEVELS register stages. Stage k holds the partial results of tree level k, a valid bit, and the beat's op.
  - Level 1 reduces a in groups of FANIN bits. Each later level reduces the previous level in groups of FANIN.
- Padding:
  - An incomplete group is padded with the identity element: 1 for AND/NAND, 0 for OR/XOR.
  - Padding must never change the result.
- NAND is computed as an AND reduction, inverted only at the final stage.
- op is captured with the beat and travels with it. Back-to-back beats may use different ops.
- Flow control is a single global advance signal:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - When advance is high, every stage loads from its predecessor, including valid. Stage 1 loads a/op/in_valid.
  - When advance is low, all stages hold.
- Bubbles: a stage whose valid bit is 0 carries don't-care data. Bubbles collapse only through advance.
- out_count increments by 1 on each out_valid && out_ready cycle and stops at 0xFFFF.
- WIDTH=1: a single stage that registers a[0], or ~a[0] for NAND.

## Timing
- Reset, on the next edge with reset=1:
  - All stage valid bits clear, so out_valid=0.
  - b=0 and out_count=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation discards every in-flight beat. No result from a beat accepted before reset ever appears.
- Latency: a beat accepted at edge t gives out_valid=1 with its b after edge t+LEVELS-1, i.e. visible in the cycle after edge t+LEVELS-1, when there is no stall.
- Throughput is one beat per cycle while out_ready=1.
- Stall:
  - out_valid=1 && out_ready=0 holds b, out_valid and all stages.
  - in_ready is 0 in the same cycle, combinationally from out_ready.
  - No beat is dropped or duplicated. Order is preserved.
- Simultaneous events:
  - Output consumed and new input accepted in the same cycle is legal and required at full rate.
  - reset overrides in_valid and out_ready.
- b and out_valid come directly from flops, with no combinational path from a. in_ready depends combinationally only on out_valid and out_ready.

## Test plan
- Walking fill, WIDTH=8, FANIN=4, op=AND, out_ready=1:
  - Stimulus: a = 0x00, 0x01, 0x03, …, 0x7F, 0xFF, one per cycle.
  - Required: b=0 for the first eight results and b=1 for the ninth (0xFF).
  - Each result appears 2 cycles after acceptance. out_count ends at 9.
- Mixed ops back-to-back, WIDTH=8:
  - Stimulus: (0x00, OR), (0x10, OR), (0x07, XOR), (0x0F, XOR), (0xFF, NAND), (0xFE, NAND).
  - Required: b = 0, 1, 1, 0, 0, 1, in order.
- Padding, WIDTH=7, FANIN=3:
  - AND 0x7F gives 1 and AND 0x3F gives 0.
  - XOR 0x40 gives 1. OR 0x00 gives 0.
- Back-pressure:
  - Stimulus: 5 consecutive valid beats with out_ready held 0 for 3 cycles after the first result.
  - Required: in_ready=0 exactly while out_valid && !out_ready, and b stays stable.
  - All 5 results are delivered in order with no gaps once out_ready=1. out_count=5.
- Reset mid-flight:
  - Stimulus: accept 2 beats, then assert reset for 1 cycle before any result emerges.
  - Required: out_valid stays 0 and b=0. out_count=0 and in_ready=1 the cycle after reset.
  - Only post-reset beats produce results.
- Counter saturation:
  - Stimulus: preload by running 65537 results with out_ready=1.
  - Required: out_count=0xFFFF and stays there, while results continue to flow correctly.

Source files
------------

// File: rtl/reduce_pipe_if.sv
// Handshake bundle for the pipelined reduction unit.
// The slave side belongs to the reduction unit; the master side belongs to
// whatever produces operands and consumes results.
interface reduce_pipe_if #(
    parameter int WIDTH = 8
);
    // Operand beat
    logic [WIDTH-1:0] a;
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;

    // Result beat
    logic             b;
    logic             out_valid;
    logic             out_ready;

    // Number of delivered results, saturating
    logic [15:0]      out_count;

    modport slave (
        input  a,
        input  op,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output b,
        output out_valid,
        output out_count
    );

    modport master (
        output a,
        output op,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  b,
        input  out_valid,
        input  out_count
    );
endinterface

// File: rtl/reduce_pipe.sv
// Pipelined N-input reduction (AND / OR / XOR / NAND) built as a tree of
// FANIN-input nodes with one register stage per tree level.
// All stages advance together on a single global enable, so a stalled output
// freezes the whole pipe and in_ready mirrors that enable.
module reduce_pipe #(
    parameter int WIDTH = 8,
    parameter int FANIN = 4
) (
    input  logic         clk,
    input  logic         reset,
    reduce_pipe_if.slave bus
);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    // Number of tree levels: smallest n with FANIN**n >= WIDTH, at least 1
    // so that a 1-bit operand still gets its register stage.
    function automatic int calc_levels();
        int     n;
        longint span;
        n    = 0;
        span = 1;
        while (span < longint'(WIDTH)) begin
            span = span * longint'(FANIN);
            n    = n + 1;
        end
        return (n < 1) ? 1 : n;
    endfunction

    // Bit count held by tree level k; level 0 is the raw operand.
    function automatic int level_width(int k);
        int w;
        w = WIDTH;
        for (int i = 0; i < k; i++) begin
            w = (w + FANIN - 1) / FANIN;
        end
        return w;
    endfunction

    // Bit position of level k (1-based) inside the packed stage vector.
    function automatic int level_offset(int k);
        int o;
        o = 0;
        for (int i = 1; i < k; i++) begin
            o = o + level_width(i);
        end
        return o;
    endfunction

    localparam int LEVELS = calc_levels();
    localparam int TOTAL  = level_offset(LEVELS + 1);

    // Partial results of every level packed back to back; the top bit is the
    // single result bit of the final level and drives b directly.
    logic [TOTAL-1:0]  data_reg;
    logic [TOTAL-1:0]  data_next;
    logic [LEVELS:1]   valid_reg;
    logic [15:0]       count_reg;
    logic              advance;

    // One enable for the whole pipe: move unless a result is waiting unread.
    assign advance = !valid_reg[LEVELS] || bus.out_ready;

    // The op of a beat rides along with its partial results. The last level
    // needs no copy because NAND inversion happens while loading it.
    genvar gi, gj, gk;
    generate
        if (LEVELS > 1) begin : g_ops
            logic [1:0] op_reg [1:LEVELS-1];

            // Shift op alongside the data on every advance.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 1; k < LEVELS; k++) begin
                        op_reg[k] <= OP_AND;
                    end
                end else if (advance) begin
                    op_reg[1] <= bus.op;
                    for (int k = 2; k < LEVELS; k++) begin
                        op_reg[k] <= op_reg[k-1];
                    end
                end
            end
        end
    endgenerate

    // Combinational tree level feeding each register stage.
    generate
        for (gi = 1; gi <= LEVELS; gi++) begin : g_lvl
            localparam int IW = level_width(gi - 1);
            localparam int OW = level_width(gi);
            localparam int OO = level_offset(gi);

            logic [IW-1:0] src;
            logic [1:0]    src_op;

            if (gi == 1) begin : g_first
                assign src    = bus.a;
                assign src_op = bus.op;
            end else begin : g_later
                assign src    = data_reg[level_offset(gi - 1) +: IW];
                assign src_op = g_ops.op_reg[gi - 1];
            end

            for (gj = 0; gj < OW; gj++) begin : g_node
                logic [FANIN-1:0] grp;
                logic             red;

                // Missing inputs of a short group take the identity element
                // so they can never influence the node result.
                for (gk = 0; gk < FANIN; gk++) begin : g_bit
                    if (gj * FANIN + gk < IW) begin : g_real
                        assign grp[gk] = src[gj * FANIN + gk];
                    end else begin : g_pad
                        assign grp[gk] = (src_op == OP_AND) || (src_op == OP_NAND);
                    end
                end

                // Node operator; NAND reduces as AND until the final level.
                always_comb begin
                    red = &grp;
                    case (src_op)
                        OP_OR:   red = |grp;
                        OP_XOR:  red = ^grp;
                        default: red = &grp;
                    endcase
                end

                if (gi == LEVELS) begin : g_final
                    assign data_next[OO + gj] = red ^ (src_op == OP_NAND);
                end else begin : g_inner
                    assign data_next[OO + gj] = red;
                end
            end
        end
    endgenerate

    // Stage registers: all levels load together or all hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg  <= '0;
            valid_reg <= '0;
        end else if (advance) begin
            data_reg     <= data_next;
            valid_reg[1] <= bus.in_valid;
            for (int k = 2; k <= LEVELS; k++) begin
                valid_reg[k] <= valid_reg[k-1];
            end
        end
    end

    // Delivered-result counter, sticks at all ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (valid_reg[LEVELS] && bus.out_ready && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.b         = data_reg[TOTAL-1];
    assign bus.out_valid = valid_reg[LEVELS];
    assign bus.out_count = count_reg;

endmodule
